router_merge: RTL and testbench

- 4-to-1 merge block; the return-path counterpart of the 1-to-4 address router.
- Four source channels contend for one output. A round-robin arbiter grants one channel per cycle. A registered output stage presents the data with the 2-bit source address, using a valid/ready handshake.
- Sits where routed traffic is collected back onto a single bus.

---
 rtl/router_pkg.sv | 7 +
 rtl/rr_arbiter4.sv | 45 ++++
 rtl/router_merge.sv | 68 ++++++
 tb/tb_router_merge.sv | 137 +++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared port-count, address and mask types for the router/merge blocks.
package router_pkg;
   localparam int NUM_PORTS   = 4;
   localparam int PORT_ADDR_W = 2;
   typedef logic [PORT_ADDR_W-1:0] port_addr_t;
   typedef logic [NUM_PORTS-1:0]   port_mask_t;
endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: 4-way round-robin arbiter starting the search after `last`.
// ROUTER_MERGE_FIXED_PRIO_EN selects fixed priority (channel 0 highest) instead.
module rr_arbiter4
   import router_pkg::*;
(
   input  port_mask_t req,
   input  port_addr_t last,
   input  logic       en,
   output port_mask_t gnt,
   output port_addr_t gnt_idx,
   output logic       any_gnt
);
   port_addr_t idx;
`ifdef ROUTER_MERGE_FIXED_PRIO_EN
   logic unused_last;
   assign unused_last = ^last;
   always_comb begin
      idx     = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         idx = port_addr_t'(k);
         if (en && req[idx]) begin
            gnt_idx = idx;
            any_gnt = 1'b1;
         end
      end
   end
`else
   // Scan farthest-first so the nearest requester after `last` wins.
   always_comb begin
      idx     = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         idx = last + port_addr_t'(k);
         if (en && req[idx]) begin
            gnt_idx = idx;
            any_gnt = 1'b1;
         end
      end
   end
`endif
   assign gnt = any_gnt ? port_mask_t'(1) << gnt_idx : '0;
endmodule

// File: rtl/router_merge.sv
// router_merge: 4-to-1 merge with arbitration and a registered valid/ready output stage.
// ROUTER_MERGE_FIXED_PRIO_EN removes the round-robin pointer for fixed priority.
module router_merge
   import router_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [DATA_WIDTH-1:0] din0,
   input  logic [DATA_WIDTH-1:0] din1,
   input  logic [DATA_WIDTH-1:0] din2,
   input  logic [DATA_WIDTH-1:0] din3,
   input  logic [NUM_PORTS-1:0]  din_en,
   output logic [NUM_PORTS-1:0]  din_ready,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_en,
   output logic [PORT_ADDR_W-1:0] dout_addr,
   input  logic                  dout_ready
);
   logic [DATA_WIDTH-1:0] dout_q, dout_d, sel;
   logic                  dout_en_q, dout_en_d;
   port_addr_t            addr_q, addr_d, last, gnt_idx;
   port_mask_t            gnt;
   logic                  load, any_gnt;
   // Gating with resetn keeps din_ready low for the whole reset window.
   assign load = (!dout_en_q || dout_ready) && resetn;
`ifdef ROUTER_MERGE_FIXED_PRIO_EN
   assign last = port_addr_t'(NUM_PORTS - 1);
`else
   port_addr_t last_q, last_d;
   assign last = last_q;
   always_comb last_d = any_gnt ? gnt_idx : last_q;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) last_q <= port_addr_t'(NUM_PORTS - 1);
      else         last_q <= last_d;
`endif
   rr_arbiter4 u_arb (
      .req     (din_en),
      .last    (last),
      .en      (load),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any_gnt (any_gnt)
   );
   assign sel = gnt_idx == 2'd0 ? din0 :
                gnt_idx == 2'd1 ? din1 :
                gnt_idx == 2'd2 ? din2 : din3;
   always_comb begin
      dout_d    = load ? (any_gnt ? sel : '0) : dout_q;
      addr_d    = load ? (any_gnt ? gnt_idx : '0) : addr_q;
      dout_en_d = load ? any_gnt : dout_en_q;
   end
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         dout_q    <= '0;
         addr_q    <= '0;
         dout_en_q <= 1'b0;
      end else begin
         dout_q    <= dout_d;
         addr_q    <= addr_d;
         dout_en_q <= dout_en_d;
      end
   assign din_ready = gnt;
   assign dout      = dout_q;
   assign dout_addr = addr_q;
   assign dout_en   = dout_en_q;
endmodule

// File: tb/tb_router_merge.sv
// tb_router_merge: directed plus random stimulus against a queue-free behavioural merge model.
module tb_router_merge;
   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] din_v [4];
   logic [3:0]  din_en;
   logic [3:0]  din_ready;
   logic [31:0] dout;
   logic        dout_en;
   logic [1:0]  dout_addr;
   logic        dout_ready;
   int n_chk = 0, n_err = 0;
   bit          m_en;
   logic [31:0] m_dout;
   int          m_addr, m_last, last_g;
   router_merge #(.DATA_WIDTH(32)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .din0       (din_v[0]),
      .din1       (din_v[1]),
      .din2       (din_v[2]),
      .din3       (din_v[3]),
      .din_en     (din_en),
      .din_ready  (din_ready),
      .dout       (dout),
      .dout_en    (dout_en),
      .dout_addr  (dout_addr),
      .dout_ready (dout_ready)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic int exp_grant(input logic [3:0] req);
`ifdef ROUTER_MERGE_FIXED_PRIO_EN
      for (int c = 0; c < 4; c++) if (req[c]) return c;
`else
      for (int d = 1; d <= 4; d++) if (req[(m_last + d) % 4]) return (m_last + d) % 4;
`endif
      return -1;
   endfunction
   task automatic model_reset();
      m_en = 0; m_dout = 0; m_addr = 0; m_last = 3;
   endtask
   task automatic step();
      int g;
      bit ld;
      #1;
      ld = !m_en || dout_ready;
      g = ld ? exp_grant(din_en) : -1;
      last_g = g;
      chk("din_ready", din_ready, g < 0 ? 0 : (1 << g));
      @(posedge clk);
      if (ld) begin
         m_en   = g >= 0;
         m_dout = g >= 0 ? din_v[g] : 0;
         m_addr = g >= 0 ? g : 0;
         if (g >= 0) m_last = g;
      end
      #1;
      chk("dout", dout, m_dout);
      chk("dout_en", dout_en, m_en);
      chk("dout_addr", dout_addr, m_addr);
      @(negedge clk);
   endtask
   initial begin
      int rr_exp [5];
`ifdef ROUTER_MERGE_FIXED_PRIO_EN
      rr_exp = '{0, 0, 0, 0, 0};
`else
      rr_exp = '{0, 1, 2, 3, 0};
`endif
      for (int i = 0; i < 4; i++) din_v[i] = 32'h1000_0000 + i;
      resetn = 1'b0; din_en = 4'hF; dout_ready = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_dout", dout, 0);
      chk("rst_dout_en", dout_en, 0);
      chk("rst_dout_addr", dout_addr, 0);
      chk("rst_din_ready", din_ready, 0);
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rr_seq", dout_addr, rr_exp[i]);
      end
      // asynchronous reset away from any clock edge
      #2 resetn = 1'b0;
      #1;
      chk("async_dout_en", dout_en, 0);
      chk("async_dout", dout, 0);
      chk("async_din_ready", din_ready, 0);
      model_reset();
      @(negedge clk);
      resetn = 1'b1;
      din_v[2] = 32'hA5A5_0002; din_en = 4'b0100;
      step();
      chk("single_dout", dout, 32'hA5A5_0002);
      chk("single_addr", dout_addr, 2);
      din_en = 4'b0010;
      step();
      dout_ready = 1'b0; din_en = 4'b1001;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_addr", dout_addr, 1);
      end
      dout_ready = 1'b1;
      step();
`ifndef ROUTER_MERGE_FIXED_PRIO_EN
      chk("bp_release_addr", dout_addr, 3);
`endif
      din_en = 4'b0000;
      step();
      chk("idle_en", dout_en, 0);
      din_en = 4'b0001;
      step();
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 4; i++) begin
            if (last_g == i || !din_en[i]) begin
               din_en[i] = $urandom_range(0, 1) != 0;
               din_v[i]  = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
               din_en[i] = 1'b0;
            end
         end
         dout_ready = $urandom_range(0, 3) != 0;
         step();
      end
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
